// File: rtl/vga_draw_pkg.sv
// Shared frame-buffer geometry, fill FSM states and the rectangle command record
// for the VGA rectangle fill engine.
package vga_draw_pkg;

  localparam int FB_WIDTH      = 160;
  localparam int FB_HEIGHT     = 120;
  localparam int FB_COLOR_BITS = 9;

  typedef enum logic [0:0] {
    FILL_IDLE = 1'b0,
    FILL_DRAW = 1'b1
  } fill_state_t;

  typedef struct packed {
    logic                     clear;
    logic [7:0]               x;
    logic [6:0]               y;
    logic [7:0]               w;
    logic [6:0]               h;
    logic [FB_COLOR_BITS-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/vga_rect_fill_engine_if.sv
// Command handshake plus pixel-write port of the rectangle fill engine.
// The processor side is the master; the engine is the slave.
interface vga_rect_fill_engine_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [8:0]  cmd_color;
  logic        busy;
  logic        enable_draw;
  logic [31:0] draw_x;
  logic [31:0] draw_y;
  logic [31:0] draw_color;

  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, enable_draw, draw_x, draw_y, draw_color
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, enable_draw, draw_x, draw_y, draw_color
  );

endinterface

// File: rtl/vga_rect_fill_engine.sv
// Rectangle-fill / screen-clear engine: one registered pixel write per clock, row-major.
// Optional VGA_FILL_CLIP_EN clamps rectangles to the 160x120 frame buffer at accept.
module vga_rect_fill_engine
  import vga_draw_pkg::*;
(
  input  logic                   Slow_Clock,
  input  logic                   Reset,
  vga_rect_fill_engine_if.slave  bus
);

  fill_state_t state_r;
  fill_state_t state_next_s;
  rect_cmd_t   cmd_s;

  logic                     accept_s;
  logic                     empty_s;
  logic                     last_pixel_s;
  logic [8:0]               x0_s;
  logic [8:0]               xend_s;
  logic [7:0]               y0_s;
  logic [7:0]               yend_s;
  logic [8:0]               x0_r;
  logic [8:0]               xend_r;
  logic [8:0]               cur_x_r;
  logic [7:0]               yend_r;
  logic [7:0]               cur_y_r;
  logic [FB_COLOR_BITS-1:0] color_r;
  logic                     enable_r;

  assign cmd_s = {bus.cmd_clear, bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h, bus.cmd_color};
  assign accept_s     = bus.cmd_valid && (state_r == FILL_IDLE);
  assign last_pixel_s = (cur_x_r == xend_r) && (cur_y_r == yend_r);

  // Rectangle bounds for the command on the bus (sums are widened so they never wrap)
  always_comb begin
    x0_s    = 9'd0;
    y0_s    = 8'd0;
    xend_s  = 9'(FB_WIDTH - 1);
    yend_s  = 8'(FB_HEIGHT - 1);
    empty_s = 1'b0;
    if (cmd_s.clear) begin
      x0_s    = 9'd0;
      y0_s    = 8'd0;
      xend_s  = 9'(FB_WIDTH - 1);
      yend_s  = 8'(FB_HEIGHT - 1);
      empty_s = 1'b0;
    end else begin
      x0_s    = {1'b0, cmd_s.x};
      y0_s    = {1'b0, cmd_s.y};
      xend_s  = x0_s + {1'b0, cmd_s.w} - 9'd1;
      yend_s  = y0_s + {1'b0, cmd_s.h} - 8'd1;
      empty_s = (cmd_s.w == 8'd0) || (cmd_s.h == 7'd0);
`ifdef VGA_FILL_CLIP_EN
      if ((x0_s >= 9'(FB_WIDTH)) || (y0_s >= 8'(FB_HEIGHT))) begin
        empty_s = 1'b1;
      end else begin
        empty_s = empty_s;
      end
      if (xend_s > 9'(FB_WIDTH - 1)) begin
        xend_s = 9'(FB_WIDTH - 1);
      end else begin
        xend_s = xend_s;
      end
      if (yend_s > 8'(FB_HEIGHT - 1)) begin
        yend_s = 8'(FB_HEIGHT - 1);
      end else begin
        yend_s = yend_s;
      end
`else
      empty_s = empty_s;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      state_r <= FILL_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: empty commands are consumed without leaving IDLE
  always_comb begin
    state_next_s = FILL_IDLE;
    case (state_r)
      FILL_IDLE: begin
        if (accept_s && !empty_s) begin
          state_next_s = FILL_DRAW;
        end else begin
          state_next_s = FILL_IDLE;
        end
      end
      FILL_DRAW: begin
        if (last_pixel_s) begin
          state_next_s = FILL_IDLE;
        end else begin
          state_next_s = FILL_DRAW;
        end
      end
      default: state_next_s = FILL_IDLE;
    endcase
  end

  // Pixel walker: latch bounds on accept, then step row-major to (xend, yend)
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      x0_r     <= 9'd0;
      xend_r   <= 9'd0;
      yend_r   <= 8'd0;
      cur_x_r  <= 9'd0;
      cur_y_r  <= 8'd0;
      color_r  <= '0;
      enable_r <= 1'b0;
    end else begin
      case (state_r)
        FILL_IDLE: begin
          if (accept_s && !empty_s) begin
            x0_r     <= x0_s;
            xend_r   <= xend_s;
            yend_r   <= yend_s;
            cur_x_r  <= x0_s;
            cur_y_r  <= y0_s;
            color_r  <= cmd_s.color;
            enable_r <= 1'b1;
          end else begin
            enable_r <= 1'b0;
          end
        end
        FILL_DRAW: begin
          if (last_pixel_s) begin
            enable_r <= 1'b0;
          end else if (cur_x_r == xend_r) begin
            cur_x_r  <= x0_r;
            cur_y_r  <= cur_y_r + 8'd1;
            enable_r <= 1'b1;
          end else begin
            cur_x_r  <= cur_x_r + 9'd1;
            enable_r <= 1'b1;
          end
        end
        default: enable_r <= 1'b0;
      endcase
    end
  end

  // FSM outputs and zero-extended pixel port
  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.busy        = 1'b0;
    case (state_r)
      FILL_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      FILL_DRAW: begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
      end
      default: begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
      end
    endcase
    bus.enable_draw = enable_r;
    bus.draw_x      = {23'd0, cur_x_r};
    bus.draw_y      = {24'd0, cur_y_r};
    bus.draw_color  = {{(32 - FB_COLOR_BITS){1'b0}}, color_r};
  end

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Directed, table-driven bench for vga_rect_fill_engine; expectations follow
// VGA_FILL_CLIP_EN when the bench is built with it.
module tb_vga_rect_fill_engine;

  typedef struct {
    logic       clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [8:0] color;
    bit         poke;
    int         exp_n;
    int         ex0;
    int         ey0;
    int         exe;
    int         eye;
  } vec_t;

  localparam int NV = 8;

  logic Slow_Clock = 1'b0;
  logic Reset      = 1'b1;
  int   passed     = 0;
  int   total      = 0;

  vga_rect_fill_engine_if bus();

  vga_rect_fill_engine dut (
    .Slow_Clock (Slow_Clock),
    .Reset      (Reset),
    .bus        (bus)
  );

  always #5 Slow_Clock = ~Slow_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive_cmd(input logic clear, input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] w, input logic [6:0] h, input logic [8:0] color);
    bus.cmd_clear = clear;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
  endtask

  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   n, cyc_err, order_err, color_err, ex, ey, lx, ly;

    vecs[0] = '{1'b0, 8'd10,  7'd20,  8'd2, 7'd2, 9'h1FF, 1'b0, 4,     10, 20, 11, 21};
    vecs[1] = '{1'b0, 8'd30,  7'd30,  8'd0, 7'd5, 9'h0F0, 1'b0, 0,     0,  0,  0,  0};
    vecs[2] = '{1'b0, 8'd30,  7'd30,  8'd3, 7'd0, 9'h0F0, 1'b0, 0,     0,  0,  0,  0};
    vecs[3] = '{1'b1, 8'd77,  7'd9,   8'd3, 7'd3, 9'h038, 1'b1, 19200, 0,  0,  159, 119};
`ifdef VGA_FILL_CLIP_EN
    vecs[4] = '{1'b0, 8'd158, 7'd118, 8'd4, 7'd4, 9'h0AA, 1'b0, 4,     158, 118, 159, 119};
    vecs[5] = '{1'b0, 8'd200, 7'd5,   8'd3, 7'd2, 9'h155, 1'b0, 0,     0,  0,  0,  0};
`else
    vecs[4] = '{1'b0, 8'd158, 7'd118, 8'd4, 7'd4, 9'h0AA, 1'b0, 16,    158, 118, 161, 121};
    vecs[5] = '{1'b0, 8'd200, 7'd5,   8'd3, 7'd2, 9'h155, 1'b0, 6,     200, 5,  202, 6};
`endif
    vecs[6] = '{1'b0, 8'd0,   7'd0,   8'd1, 7'd1, 9'h001, 1'b0, 1,     0,  0,  0,  0};
    vecs[7] = '{1'b0, 8'd157, 7'd119, 8'd3, 7'd1, 9'h100, 1'b0, 3,     157, 119, 159, 119};

    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.cmd_x     = 8'd0;
    bus.cmd_y     = 7'd0;
    bus.cmd_w     = 8'd0;
    bus.cmd_h     = 7'd0;
    bus.cmd_color = 9'd0;

    // Reset held for three cycles
    Reset = 1'b1;
    repeat (3) @(posedge Slow_Clock);
    @(negedge Slow_Clock);
    check("rst_ready",  {31'd0, bus.cmd_ready},   32'd1);
    check("rst_busy",   {31'd0, bus.busy},        32'd0);
    check("rst_enable", {31'd0, bus.enable_draw}, 32'd0);
    check("rst_x",      bus.draw_x,               32'd0);
    check("rst_y",      bus.draw_y,               32'd0);
    check("rst_color",  bus.draw_color,           32'd0);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge Slow_Clock);
      check($sformatf("v%0d_ready_pre", i), {31'd0, bus.cmd_ready}, 32'd1);
      drive_cmd(v.clear, v.x, v.y, v.w, v.h, v.color);
      @(posedge Slow_Clock);
      n = 0; cyc_err = 0; order_err = 0; color_err = 0;
      ex = v.ex0; ey = v.ey0; lx = -1; ly = -1;
      for (int c = 1; c <= v.exp_n + 4; c++) begin
        @(negedge Slow_Clock);
        if (c == 1) bus.cmd_valid = 1'b0;
        if (v.poke && c == 100) drive_cmd(1'b0, 8'd5, 7'd5, 8'd5, 7'd5, 9'h007);
        if (v.poke && c == 101) bus.cmd_valid = 1'b0;
        if (bus.enable_draw !== (c <= v.exp_n)) cyc_err++;
        if (bus.busy        !== (c <= v.exp_n)) cyc_err++;
        if (bus.cmd_ready   !== (c >  v.exp_n)) cyc_err++;
        if (bus.enable_draw === 1'b1) begin
          n++;
          if (bus.draw_x !== 32'(ex) || bus.draw_y !== 32'(ey)) order_err++;
          if (bus.draw_color !== {23'd0, v.color}) color_err++;
          lx = int'(bus.draw_x);
          ly = int'(bus.draw_y);
          if (ex == v.exe) begin
            ex = v.ex0;
            ey++;
          end else begin
            ex++;
          end
        end
      end
      check($sformatf("v%0d_count", i),      32'(n),         32'(v.exp_n));
      check($sformatf("v%0d_timing", i),     32'(cyc_err),   32'd0);
      check($sformatf("v%0d_order", i),      32'(order_err), 32'd0);
      check($sformatf("v%0d_color", i),      32'(color_err), 32'd0);
      if (v.exp_n > 0) begin
        check($sformatf("v%0d_last_x", i), 32'(lx), 32'(v.exe));
        check($sformatf("v%0d_last_y", i), 32'(ly), 32'(v.eye));
      end
    end

    // Reset asserted after the fifth pixel of an 8x8 rectangle
    @(negedge Slow_Clock);
    drive_cmd(1'b0, 8'd40, 7'd50, 8'd8, 7'd8, 9'h0C3);
    @(posedge Slow_Clock);
    n = 0;
    for (int c = 1; c <= 20 && n < 5; c++) begin
      @(negedge Slow_Clock);
      bus.cmd_valid = 1'b0;
      if (bus.enable_draw === 1'b1) n++;
    end
    check("mid_rst_pixels_before", 32'(n), 32'd5);
    Reset = 1'b1;
    @(negedge Slow_Clock);
    check("mid_rst_enable", {31'd0, bus.enable_draw}, 32'd0);
    check("mid_rst_ready",  {31'd0, bus.cmd_ready},   32'd1);
    check("mid_rst_busy",   {31'd0, bus.busy},        32'd0);
    check("mid_rst_x",      bus.draw_x,               32'd0);
    Reset = 1'b0;
    n = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge Slow_Clock);
      if (bus.enable_draw === 1'b1) n++;
    end
    check("mid_rst_no_more_pixels", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
